// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state and owner encodings shared by the arbiter and its users
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic {CPU = 1'b0, DMA = 1'b1} owner_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA arbiter in front of a single-port synchronous memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic [DATA_W/8-1:0] dma_be,
  output logic                dma_ack,
  output logic [DATA_W-1:0]   dma_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d, last_q, last_d;
  logic   sel_dma, in_addr, in_resp, other_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= CPU;
      last_q  <= DMA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign sel_dma   = owner_q == DMA;
  assign in_addr   = state_q == ADDR;
  assign in_resp   = state_q == RESP;
  assign other_req = sel_dma ? cpu_req : dma_req;

  // In RESP only the non-owner may claim the next slot, which bounds each side's wait to one access
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (cpu_req || dma_req) begin
        state_d = ADDR;
        owner_d = (cpu_req && dma_req) ? ((last_q == CPU) ? DMA : CPU) : (cpu_req ? CPU : DMA);
      end
      ADDR: state_d = RESP;
      RESP: begin
        last_d  = owner_q;
        state_d = other_req ? ADDR : IDLE;
        owner_d = other_req ? (sel_dma ? CPU : DMA) : owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = in_addr;
  assign mem_we    = in_addr && (sel_dma ? dma_we : cpu_we);
  assign mem_addr  = in_addr ? (sel_dma ? dma_addr : cpu_addr) : '0;
  assign mem_wdata = in_addr ? (sel_dma ? dma_wdata : cpu_wdata) : '0;
  assign mem_be    = in_addr ? (sel_dma ? dma_be : cpu_be) : '0;
  assign cpu_ack   = in_resp && !sel_dma;
  assign dma_ack   = in_resp && sel_dma;
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign dma_rdata = dma_ack ? mem_rdata : '0;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of all address ports.
REQ-002 Parameter: DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 clk  input  1  clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cpu_req  input  1  CPU access request; held high until cpu_ack.
REQ-006 cpu_we, cpu_addr, cpu_wdata, cpu_be  input  1/ADDR_W/DATA_W/DATA_W/8  CPU access attributes; stable while cpu_req is high.
REQ-007 cpu_ack  output  1  one-cycle pulse marking completion of the CPU access.
REQ-008 cpu_rdata  output  DATA_W  read data; valid only while cpu_ack is high.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_ack, dma_rdata  same directions, widths and meaning as the cpu_* set.
REQ-010 mem_en, mem_we  output  1  single-port synchronous memory enable and write strobe.
REQ-011 mem_addr, mem_wdata, mem_be  output  ADDR_W/DATA_W/DATA_W/8  memory address, write data and byte enables.
REQ-012 mem_rdata  input  DATA_W  memory read data, valid one cycle after the mem_en cycle.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADDR and RESP, plus an owner register (CPU/DMA) and a last_owner register.
REQ-014 IDLE: one request -> ADDR with owner = that requester; both requesting -> owner = requester that is not last_owner; no request -> stay in IDLE.
REQ-015 ADDR: mem_en=1 and mem_we/addr/wdata/be = the owner's inputs; the next state SHALL be RESP.
REQ-016 RESP: owner's ack=1 and owner's rdata=mem_rdata; last_owner:=owner; mem_en=0 and mem_we=0.
REQ-017 RESP arbitration SHALL consider only the non-owner's req: high -> ADDR with owner switched, else -> IDLE.
REQ-018 An owner whose req is still high in the cycle after its ack SHALL be treated as presenting a new request.
REQ-019 Access latency: req sampled in IDLE -> ack 2 cycles later; sustained throughput 1 access per 2 cycles.
REQ-020 Outside ADDR, mem_en, mem_we and mem_be SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-021 The non-owner's ack SHALL be 0 in every cycle; cpu_ack and dma_ack SHALL never be high simultaneously.
REQ-022 rdata outputs SHALL be 0 whenever the corresponding ack is 0.
REQ-023 Writes SHALL also complete with an ack pulse in RESP; rdata content on a write ack is don't-care.
REQ-024 Simultaneous requests in IDLE after reset SHALL grant CPU first.
REQ-025 Neither requester SHALL wait more than one other access when both request continuously.

Reset
REQ-026 While rst is high: state=IDLE, owner=CPU, last_owner=DMA, and all outputs 0.
REQ-027 rst asserted mid-access (in ADDR or RESP) SHALL abort that access with no ack; the requester re-issues it after reset.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE/ADDR/RESP) and the owner encoding (CPU=0, DMA=1).
REQ-029 The design SHALL be one module with no sub-modules; the two-way round-robin pick is local logic.

Verification
REQ-030 CPU read only: cpu_req with addr 0x10, memory holding 0xDEADBEEF -> mem_en at cycle 1, cpu_ack plus rdata 0xDEADBEEF at cycle 2, dma_ack stays 0.
REQ-031 Simultaneous requests after reset: cpu and dma req high together -> CPU ADDR at cycle 1, CPU ack at cycle 2, DMA ADDR at cycle 3, DMA ack at cycle 4.
REQ-032 Continuous contention for 8 accesses -> grants alternate C,D,C,D...; 4 acks to each requester within 16 cycles.
REQ-033 DMA byte write with be=0x2, wdata=0x0000AB00, addr 0x20 -> single cycle with mem_we=1 and mem_be=0x2, dma_ack next cycle; a CPU read of 0x20 afterwards returns byte 1 = 0xAB.
REQ-034 rst pulsed during RESP of a CPU access -> no cpu_ack, all outputs 0 during reset, CPU granted first after release.
REQ-035 Requester holds req across its ack -> second access is issued; no ack is lost or duplicated, as checked by counting acks.
